// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 3x3 convolution engine.
//   KSIZE / NTAPS : kernel edge length and number of taps
//   state_e       : control FSM states
//   acc_width()   : accumulator width able to hold the sum of 9 full-scale products
package conv_pkg;

   localparam int KSIZE = 3;
   localparam int NTAPS = KSIZE * KSIZE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Each product needs 2*data_w bits. Summing 9 of them needs 4 guard bits
   // (ceil(log2(9)) = 4).
   function automatic int acc_width(input int data_w);
      return 2 * data_w + 4;
   endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// Two-row line buffer, 3x3 sliding window and raster row/col counters.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (counters only)
//   clear_i       : restart the raster position at (0,0) for a new frame
//   accept_i      : a pixel is accepted this cycle
//   pix_i         : accepted pixel value
//   win_o         : window including the pixel being accepted, row-major,
//                   tap 0 = oldest row / oldest column
//   win_valid_o   : accepted pixel completes a valid-mode window
//   win_last_o    : accepted pixel is the final pixel of the frame
module conv_window_buffer
   import conv_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     accept_i,
   input  logic signed [DATA_W-1:0] pix_i,
   output logic signed [DATA_W-1:0] win_o [NTAPS],
   output logic                     win_valid_o,
   output logic                     win_last_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic signed [DATA_W-1:0] lb0_q [IMG_W];  // previous row
   logic signed [DATA_W-1:0] lb1_q [IMG_W];  // row before that
   logic signed [DATA_W-1:0] win_q [NTAPS];
   logic                     at_eol;

   assign at_eol = (col_q == CW'(IMG_W - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         col_d = '0;
         row_d = '0;
      end else if (accept_i) begin
         if (at_eol) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // The window is presented already shifted with the incoming column so the
   // multiplier stage can register products on the same edge the pixel is
   // accepted; this is what gives the two-cycle pixel-to-output latency.
   always_comb begin
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE - 1; c++) begin
            win_o[r*KSIZE + c] = win_q[r*KSIZE + c + 1];
         end
      end
      win_o[0*KSIZE + KSIZE - 1] = lb1_q[col_q];
      win_o[1*KSIZE + KSIZE - 1] = lb0_q[col_q];
      win_o[2*KSIZE + KSIZE - 1] = pix_i;
   end

   // Pixel storage carries no reset: its contents before a row is refilled
   // never reach a valid window.
   always_ff @(posedge clk) begin
      if (accept_i) begin
         win_q        <= win_o;
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= pix_i;
      end
   end

   assign win_valid_o = accept_i && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign win_last_o  = accept_i && (row_q == RW'(IMG_H - 1)) && at_eol;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid-mode convolution engine with runtime-loadable kernel.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   start, relu_en                 : begin frame (IDLE only), ReLU select latched on start
//   wt_valid, wt_data              : kernel load beats k00..k22 (IDLE only)
//   pix_valid, pix_ready, pix_data : raster-order pixel stream in
//   out_valid, out_ready, out_data : convolution results out
//   out_last                       : final result of the frame
//   busy, done                     : frame in progress / one-cycle completion pulse
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ACC_W  = acc_width(DATA_W)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     relu_en,
   input  logic                     wt_valid,
   input  logic signed [DATA_W-1:0] wt_data,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic signed [DATA_W-1:0] pix_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int PROD_W = 2 * DATA_W;

   state_e                   state_q, state_d;
   logic [3:0]               wt_idx_q, wt_idx_d;
   logic signed [DATA_W-1:0] kern_q [NTAPS];
   logic                     relu_q;

   logic                     adv, accept;
   logic signed [DATA_W-1:0] win [NTAPS];
   logic                     win_valid, win_last;

   logic signed [PROD_W-1:0] prod_p1_q [NTAPS];
   logic                     vld_p1_q, last_p1_q;
   logic signed [ACC_W-1:0]  sum_p1;

   logic signed [ACC_W-1:0]  out_data_q;
   logic                     out_valid_q, out_last_q;

   function automatic logic signed [ACC_W-1:0] apply_relu(input logic signed [ACC_W-1:0] v,
                                                          input logic                    en);
      return (en && v[ACC_W-1]) ? '0 : v;
   endfunction

   // A full output register that is not being taken freezes the whole pipe.
   assign adv       = !out_valid_q || out_ready;
   assign pix_ready = (state_q == RUN) && adv;
   assign accept    = pix_valid && pix_ready;

   conv_window_buffer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H)
   ) u_winbuf (
      .clk         (clk),
      .rst         (rst),
      .clear_i     ((state_q == IDLE) && start),
      .accept_i    (accept),
      .pix_i       (pix_data),
      .win_o       (win),
      .win_valid_o (win_valid),
      .win_last_o  (win_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (win_last) state_d = DRAIN;
         DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A weight beat coinciding with start is still written; the index clear
   // from start then takes priority.
   always_comb begin
      wt_idx_d = wt_idx_q;
      if (state_q == IDLE) begin
         if (wt_valid) wt_idx_d = (wt_idx_q == 4'(NTAPS - 1)) ? '0 : wt_idx_q + 4'd1;
         if (start)    wt_idx_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wt_idx_q <= '0;
         relu_q   <= 1'b0;
         for (int i = 0; i < NTAPS; i++) kern_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         wt_idx_q <= wt_idx_d;
         if (state_q == IDLE) begin
            if (wt_valid) kern_q[wt_idx_q] <= wt_data;
            if (start)    relu_q <= relu_en;
         end
      end
   end

   // ---- stage 1: nine signed products ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         last_p1_q <= 1'b0;
      end else if (adv) begin
         vld_p1_q  <= win_valid;
         last_p1_q <= win_last;
      end
   end

   always_ff @(posedge clk) begin
      if (adv && win_valid) begin
         for (int i = 0; i < NTAPS; i++) begin
            prod_p1_q[i] <= PROD_W'(win[i]) * PROD_W'(kern_q[i]);
         end
      end
   end

   always_comb begin
      sum_p1 = '0;
      for (int i = 0; i < NTAPS; i++) sum_p1 = sum_p1 + ACC_W'(prod_p1_q[i]);
   end

   // ---- stage 2: adder tree, ReLU, output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         out_valid_q <= vld_p1_q;
         out_last_q  <= last_p1_q;
         if (vld_p1_q) out_data_q <= apply_relu(sum_p1, relu_q);
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule
